// File: rtl/btn_pkg.sv
// btn_pkg: shared definitions for the pushbutton debounce/pulse block.
// Holds the per-channel state encoding and the default configuration constants
// used by debounce_channel and btn_debounce_pulse.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } chan_state_t;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 1000000;  // 10 ms at 100 MHz
  localparam int DEF_CNT_W           = 20;       // 2**20 > 1000000
  localparam int DEF_REPEAT_CYCLES   = 50000000; // 0.5 s at 100 MHz

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one pushbutton conditioning channel.
// Synchronises a raw asynchronous button, debounces it with a counter FSM and
// produces a registered debounced level plus a one-cycle press pulse.
// Optional build macro: AUTO_REPEAT_EN (adds REPEAT_CYCLES and a repeat counter
// that re-pulses while the button stays held).
// Ports:
//   clk    in  system clock, rising edge
//   reset  in  asynchronous, active-high; clears all state
//   raw    in  raw button input, asynchronous to clk
//   pulse  out one-cycle pulse on each accepted press (and each repeat)
//   lvl    out debounced level
module debounce_channel
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
`ifdef AUTO_REPEAT_EN
  ,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic pulse,
  output logic lvl
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef AUTO_REPEAT_EN
  localparam int RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
  logic [RPT_W-1:0] rpt_reg;
`endif

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   s;
  chan_state_t            state_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic                   pulse_reg;
  logic                   lvl_reg;

  // Synchroniser chain: bit 0 samples the raw pin, the top bit is the clean copy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw};
    end
  end

  assign s = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      pulse_reg <= 1'b0;
      lvl_reg   <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rpt_reg   <= '0;
`endif
    end else begin
      pulse_reg <= 1'b0;  // pulse is high for one cycle only
      case (state_reg)
        IDLE: begin
          if (s) begin
            state_reg <= PRESS_WAIT;
            cnt_reg   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state_reg <= IDLE;  // bounce: no pulse
          end else if (cnt_reg == CNT_LAST) begin
            state_reg <= HELD;
            lvl_reg   <= 1'b1;
            pulse_reg <= 1'b1;
`ifdef AUTO_REPEAT_EN
            rpt_reg   <= '0;
`endif
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        HELD: begin
          if (!s) begin
            // Repeat counter is deliberately left untouched (frozen) here.
            state_reg <= RELEASE_WAIT;
            cnt_reg   <= '0;
          end
`ifdef AUTO_REPEAT_EN
          else if (rpt_reg == RPT_LAST) begin
            pulse_reg <= 1'b1;
            rpt_reg   <= '0;
          end else begin
            rpt_reg <= rpt_reg + 1'b1;
          end
`endif
        end
        RELEASE_WAIT: begin
          if (s) begin
            state_reg <= HELD;  // release bounce: back to held, no new pulse
`ifdef AUTO_REPEAT_EN
            rpt_reg   <= '0;
`endif
          end else if (cnt_reg == CNT_LAST) begin
            state_reg <= IDLE;
            lvl_reg   <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign pulse = pulse_reg;
  assign lvl   = lvl_reg;

endmodule

// File: rtl/btn_debounce_pulse.sv
// btn_debounce_pulse: conditions two raw pushbuttons for the P1/P2 sequence
// detector. Each button gets an independent debounce_channel; the channels
// are not arbitrated, so both pulses may fire in the same cycle.
// Optional build macro: AUTO_REPEAT_EN (auto-repeat pulses while held,
// interval REPEAT_CYCLES).
// Ports:
//   clk       in  system clock, rising edge
//   reset     in  asynchronous, active-high; clears all state
//   btn1_raw  in  raw pushbutton 1
//   btn2_raw  in  raw pushbutton 2
//   P1, P2    out one-cycle press pulses (to detector P1/P2)
//   P1_lvl    out debounced level, channel 1
//   P2_lvl    out debounced level, channel 2
module btn_debounce_pulse
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
`ifdef AUTO_REPEAT_EN
  ,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic btn1_raw,
  input  logic btn2_raw,
  output logic P1,
  output logic P2,
  output logic P1_lvl,
  output logic P2_lvl
);

  logic [1:0] raw_vec;
  logic [1:0] pulse_vec;
  logic [1:0] lvl_vec;

  assign raw_vec = {btn2_raw, btn1_raw};

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_chan
    debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
`ifdef AUTO_REPEAT_EN
      ,
      .REPEAT_CYCLES  (REPEAT_CYCLES)
`endif
    ) u_chan (
      .clk  (clk),
      .reset(reset),
      .raw  (raw_vec[gi]),
      .pulse(pulse_vec[gi]),
      .lvl  (lvl_vec[gi])
    );
  end

  assign P1     = pulse_vec[0];
  assign P2     = pulse_vec[1];
  assign P1_lvl = lvl_vec[0];
  assign P2_lvl = lvl_vec[1];

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Directed bench for btn_debounce_pulse with SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
// so a qualified press/release shows up 7 edges after the raw change.
module tb_btn_debounce_pulse;

`ifdef AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic btn1_raw, btn2_raw;
  logic P1, P2, P1_lvl, P2_lvl;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic b1;
    logic b2;
    logic [3:0] exp;  // {P1, P2, P1_lvl, P2_lvl}
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  btn_debounce_pulse #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
`ifdef AUTO_REPEAT_EN
    ,
    .REPEAT_CYCLES  (10)
`endif
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn1_raw(btn1_raw),
    .btn2_raw(btn2_raw),
    .P1      (P1),
    .P2      (P2),
    .P1_lvl  (P1_lvl),
    .P2_lvl  (P2_lvl)
  );

  function automatic logic [3:0] outs();
    return {P1, P2, P1_lvl, P2_lvl};
  endfunction

  task automatic push(input logic b1, input logic b2, input logic p1,
                      input logic p2, input logic l1, input logic l2);
    vec_t v;
    v.b1 = b1; v.b2 = b2; v.exp = {p1, p2, l1, l2};
    vecs.push_back(v);
  endtask

  task automatic compare(input string name, input int k, input logic [3:0] exp);
    logic [3:0] got;
    got = outs();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got P1,P2,L1,L2=%b expected %b", name, k, got, exp);
    end else begin
      $display("ok   %s step %0d in=%b%b out=%b", name, k, btn1_raw, btn2_raw, got);
    end
  endtask

  // Drive inputs, take one clock edge, sample 1 time unit after it.
  task automatic step_chk(input string name, input int k, input logic b1,
                          input logic b2, input logic [3:0] exp);
    btn1_raw = b1;
    btn2_raw = b2;
    @(posedge clk);
    #1;
    compare(name, k, exp);
  endtask

  initial begin
    int pulses;
    logic [3:0] e;

    // Table: clean press/release on ch1, then simultaneous press/release.
    for (int k = 1; k <= 20; k++) push(1, 0, k == 7, 0, k >= 7, 0);
    for (int k = 1; k <= 10; k++) push(0, 0, 0, 0, k < 7, 0);
    for (int k = 1; k <= 10; k++) push(1, 1, k == 7, k == 7, k >= 7, k >= 7);
    for (int k = 1; k <= 10; k++) push(0, 0, 0, 0, k < 7, k < 7);

    reset = 1'b1;
    btn1_raw = 1'b0;
    btn2_raw = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compare("reset_state", 0, 4'b0000);
    reset = 1'b0;

    foreach (vecs[i]) step_chk("table", i, vecs[i].b1, vecs[i].b2, vecs[i].exp);

    // Press bounce 1,1,0,0,1,1,0,0 then steady 1: pulse 7 edges after final rise (step 9).
    for (int k = 1; k <= 22; k++) begin
      logic b;
      b = (k <= 8) ? (((k - 1) / 2) % 2 == 0) : 1'b1;
      step_chk("press_bounce", k, b, 0, {k == 15, 1'b0, k >= 15, 1'b0});
    end

    // Release bounce: 2 cycles low then high again -> stays held, no pulse.
    for (int k = 1; k <= 12; k++) step_chk("release_bounce", k, k > 2, 0, 4'b0010);
    for (int k = 1; k <= 10; k++) step_chk("clean_release", k, 0, 0, {2'b00, k < 7, 1'b0});

    // Ch2 held, then reset asynchronously clears the level.
    for (int k = 1; k <= 8; k++) step_chk("ch2_hold", k, 0, 1, {1'b0, k == 7, 1'b0, k >= 7});
    reset = 1'b1;
    #1;
    compare("async_reset_held", 0, 4'b0000);
    for (int k = 1; k <= 2; k++) step_chk("in_reset", k, 0, 1, 4'b0000);
    reset = 1'b0;
    for (int k = 1; k <= 10; k++) step_chk("ch2_requal", k, 0, 1, {1'b0, k == 7, 1'b0, k >= 7});
    for (int k = 1; k <= 10; k++) step_chk("ch2_release", k, 0, 0, {3'b000, k < 7});

    // Reset mid PRESS_WAIT on ch1 with button still held.
    for (int k = 1; k <= 5; k++) step_chk("ch1_precount", k, 1, 0, 4'b0000);
    reset = 1'b1;
    #1;
    compare("async_reset_count", 0, 4'b0000);
    for (int k = 1; k <= 2; k++) step_chk("in_reset", k, 1, 0, 4'b0000);
    reset = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      step_chk("ch1_after_reset", k, 1, 0, {k == 7, 1'b0, k >= 7, 1'b0});
      if (P1) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL ch1_after_reset_pulses: got %0d pulses expected 1", pulses);
    end
    for (int k = 1; k <= 10; k++) step_chk("ch1_release", k, 0, 0, {2'b00, k < 7, 1'b0});

    // Long hold on ch2: repeats every 10 cycles only when auto-repeat is built in.
    pulses = 0;
    for (int k = 1; k <= 47; k++) begin
      e = {1'b0, (k == 7) || (AR && k > 7 && ((k - 7) % 10 == 0)), 1'b0, k >= 7};
      step_chk("long_hold", k, 0, 1, e);
      if (P2) pulses++;
    end
    checks++;
    if (pulses != (AR ? 5 : 1)) begin
      errors++;
      $display("FAIL long_hold_pulses: got %0d pulses expected %0d", pulses, AR ? 5 : 1);
    end
    for (int k = 1; k <= 10; k++) step_chk("long_release", k, 0, 0, {3'b000, k < 7});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
